// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : DLX WB stage - register-file write, late-load wait, retire count.
// Revision : 1.0
// ============================================================================
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic        clock5,
    input  logic        reset5,
    input  logic        valid_in5,
    input  logic [31:0] inst_in5,
    input  logic [31:0] aluout_in5,
    input  logic [31:0] lmd_in5,
    input  logic        lmd_valid5,
    output logic        stall5,
    output logic        reg_write_en,
    output logic [4:0]  reg_add_out,
    output logic [31:0] reg_data_out,
    output logic [31:0] irout5,
    output logic        load_err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    localparam logic [7:0] C_TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  tcnt_q;
    logic [4:0]  pend_dest_q;
    logic        we_q;
    logic [4:0]  add_q;
    logic [31:0] data_q;
    logic [31:0] ir_q;
    logic        err_q;
    logic [31:0] retire_cnt_q;

    logic        is_load_d;
    logic        is_alu_d;
    logic [4:0]  dest_d;

    always_comb begin
        is_load_d = 1'b0;
        is_alu_d  = 1'b0;
        dest_d    = inst_in5[20:16];
        case (inst_in5[31:26])
            6'b000010: is_load_d = 1'b1;
            6'b010000, 6'b010010, 6'b010100, 6'b010101, 6'b010110,
            6'b011010, 6'b011011, 6'b011100, 6'b011101, 6'b011110,
            6'b011111: is_alu_d = 1'b1;
            6'b110000: begin
                is_alu_d = 1'b1;
                dest_d   = inst_in5[15:11];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock5) begin
        if (reset5) begin
            state_q      <= S_IDLE;
            tcnt_q       <= 8'd0;
            pend_dest_q  <= 5'd0;
            we_q         <= 1'b0;
            add_q        <= 5'd0;
            data_q       <= 32'd0;
            ir_q         <= 32'd0;
            err_q        <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_in5) begin
                        ir_q <= inst_in5;
                        if (is_load_d && !lmd_valid5) begin
                            pend_dest_q <= dest_d;
                            tcnt_q      <= 8'd0;
                            state_q     <= S_WAIT_LOAD;
                        end else begin
                            retire_cnt_q <= retire_cnt_q + 32'd1;
                            // r0 is hard-wired zero: retire without a strobe
                            if ((is_alu_d || is_load_d) && (dest_d != 5'd0)) begin
                                we_q   <= 1'b1;
                                add_q  <= dest_d;
                                data_q <= is_load_d ? lmd_in5 : aluout_in5;
                            end
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (lmd_valid5) begin
                        retire_cnt_q <= retire_cnt_q + 32'd1;
                        if (pend_dest_q != 5'd0) begin
                            we_q   <= 1'b1;
                            add_q  <= pend_dest_q;
                            data_q <= lmd_in5;
                        end
                        state_q <= S_IDLE;
                    end else if (tcnt_q == C_TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall5       = (state_q == S_WAIT_LOAD);
    assign reg_write_en = we_q;
    assign reg_add_out  = add_q;
    assign reg_data_out = data_q;
    assign irout5       = ir_q;
    assign load_err     = err_q;
    assign retire_cnt   = retire_cnt_q;

endmodule
`default_nettype wire
